wallace_final_cpa: RTL
======================

// Module: wallace_final_cpa
// PURPOSE
// - Final carry-propagate stage of the 32x32 Wallace tree multiplier: adds the two
//   reduced rows (sum row, carry row) from the last fulladder compression level into the product.
// - Sits directly downstream of the Wallace reduction tree.
// - Pipelined in CHUNK-bit slices, one slice per cycle, to keep the ripple path short.
// - Valid/ready handshake on both sides; accepts one operand pair per cycle at full throughput.
// PARAMETERS
// - W      64  width of sum_row, carry_row and product; must be a multiple of CHUNK
// - CHUNK  16  bits added per pipeline stage
// - STAGES     derived localparam = W/CHUNK (4 at defaults); not overridable
// PORTS
// - clk        in   1  single clock; all state on rising edge
// - rst_n      in   1  asynchronous, active-low reset
// - in_valid   in   1  sum_row/carry_row valid this cycle
// - in_ready   out  1  block accepts the pair this cycle
// - sum_row    in   W  sum row from the tree; bit i has weight 2^i
// - carry_row  in   W  carry row, already aligned by the tree; bit i has weight 2^i
// - out_valid  out  1  product valid
// - out_ready  in   1  consumer accepts product
// - product    out  W  (sum_row + carry_row) mod 2^W
// - cout       out  1  carry out of bit W-1; always 0 for a legal 32x32 product
// BEHAVIOUR
// - Reset (rst_n=0, async): all stage valids=0, out_valid=0, product=0, cout=0.
//   in_ready=1 once reset is released.
// - Transfer rule: a transfer occurs on a rising edge where valid && ready.
// - Pipeline: stage k (0..STAGES-1) registers:
//   - result bits [k*CHUNK +: CHUNK] = chunk_k(sum) + chunk_k(carry) + c_k
//   - c_{k+1}, the carry out of that slice
//   - the untouched upper operand slices
//   - the lower result slices already computed
//   - c_0 = 0
// - Latency: exactly STAGES cycles from input handshake to out_valid, with no stalls.
//   - The last stage's registers drive product/cout directly.
// - Flow control: per-stage valid bit. stage_adv[k] = !v[k] || stage_adv[k+1].
//   - stage_adv[STAGES] = out_ready.
//   - in_ready = stage_adv[0], combinational from out_ready.
//   - Bubbles collapse: an empty stage fills even while downstream stalls.
// - Stall: a stage that cannot advance holds its data and valid unchanged.
//   - product/cout stay stable while out_valid && !out_ready (AXI-style hold).
// - Simultaneous in/out handshake: when all stages are full and out_ready=1, the whole
//   pipe shifts and a new pair enters the same cycle. Sustained throughput is 1 per cycle.
// - Arithmetic:
//   - Unsigned modulo 2^W; cout is the exact carry out of the W-bit add.
//   - All-ones + 1 gives product=0, cout=1.
// - Reset mid-operation: all in-flight results are discarded and nothing is emitted
//   after release until new inputs arrive.
// - Non-valid stages hold their data registers (no reset-to-zero requirement for
//   datapath bits other than product/cout).
// STRUCTURE
// - Shared package wallace_pkg: MUL_N=32, PROD_W=2*MUL_N, CPA_CHUNK=16.
//   W and CHUNK defaults are taken from it.
// - One sub-module, cpa_chunk:
//   - CHUNK-bit ripple adder built from the existing fulladder cell.
//   - Ports: a, b, cin, sum, cout.
//   - Instanced once per stage via generate.
// - Top module holds only the stage registers, valid chain and handshake logic.
// TESTING
// - Reset then a single pair sum=64'h0000_0000_FFFF_FFFF, carry=64'h1 ->
//   exactly 4 cycles later out_valid=1, product=64'h0000_0001_0000_0000, cout=0.
// - Carry ripple across all slices: sum=64'hFFFF_FFFF_FFFF_FFFF, carry=64'h1 ->
//   product=0, cout=1, delivered after 4 cycles.
// - Streaming: 16 back-to-back pairs with out_ready=1 ->
//   16 consecutive out_valid cycles, results in order, in_ready never drops.
// - Backpressure: stream 8 pairs, hold out_ready=0 for 10 cycles ->
//   - in_ready falls after 4 accepted (pipe full)
//   - product stable during the stall
//   - all 8 emitted in order after release
// - Reset mid-stream: assert rst_n=0 with 3 pairs in flight ->
//   - out_valid=0 immediately (async)
//   - no stale products after release
//   - the next pair is delivered in 4 cycles
// - Random: 10k random 32x32 operand pairs run through a reference tree model,
//   with random out_ready -> product == a*b for every output, and cout==0.

Source files
------------

// File: rtl/wallace_pkg.sv
// Shared sizing for the 32x32 Wallace multiplier and its final carry-propagate adder.
package wallace_pkg;
    localparam int MUL_N     = 32;
    localparam int PROD_W    = 2 * MUL_N;
    localparam int CPA_CHUNK = 16;
endpackage

// File: rtl/cpa_chunk.sv
// N-bit ripple-carry slice of the final adder, chained from fulladder cells.
// Latency: combinational.
// Backpressure: none, pure logic.
module cpa_chunk
    import wallace_pkg::*;
#(
    parameter int N = CPA_CHUNK
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic [N:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        fulladder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .sum  (sum[i]),
            .cout (c[i+1])
        );
    end

    assign cout = c[N];
endmodule

// File: rtl/fulladder.sv
// One-bit full adder cell used by the compression tree and the final adder.
// Latency: combinational.
// Backpressure: none, pure logic.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/wallace_final_cpa.sv
// Final carry-propagate add of the Wallace sum/carry rows, one CHUNK-bit slice per stage.
// Latency: W/CHUNK cycles from input handshake to out_valid, one pair per cycle throughput.
// Backpressure: per-stage valid chain; a full stage stalls only when everything below it is full.
module wallace_final_cpa
    import wallace_pkg::*;
#(
    parameter int W     = PROD_W,
    parameter int CHUNK = CPA_CHUNK
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] sum_row,
    input  logic [W-1:0] carry_row,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] product,
    output logic         cout
);
    localparam int STAGES = W / CHUNK;

    logic [STAGES-1:0] v_vec;
    logic [STAGES-1:0] adv;
    logic              all_full;

    // A stage may load when it is empty or some stage at/after it can drain.
    always_comb begin
        all_full = 1'b1;
        adv      = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            all_full = all_full & v_vec[k];
            adv[k]   = out_ready | ~all_full;
        end
    end

    assign in_ready = adv[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CHUNK;
        localparam int RW = W - LO;

        logic [W-1:0]     s_in;
        logic [W-1:0]     s_nxt;
        logic [W-1:0]     s_q;
        logic [RW-1:0]    c_in;
        logic             cin;
        logic             v_in;
        logic             v_q;
        logic             cy_q;
        logic [CHUNK-1:0] add_sum;
        logic             add_co;

        if (k == 0) begin : g_src
            assign s_in = sum_row;
            assign c_in = carry_row;
            assign cin  = 1'b0;
            assign v_in = in_valid;
        end else begin : g_src
            assign s_in = g_stage[k-1].s_q;
            assign c_in = g_stage[k-1].g_hold.c_q;
            assign cin  = g_stage[k-1].cy_q;
            assign v_in = g_stage[k-1].v_q;
        end

        cpa_chunk #(.N(CHUNK)) u_chunk (
            .a    (s_in[LO +: CHUNK]),
            .b    (c_in[CHUNK-1:0]),
            .cin  (cin),
            .sum  (add_sum),
            .cout (add_co)
        );

        // s_q carries finished low slices plus not-yet-added upper sum slices.
        always_comb begin
            s_nxt              = s_in;
            s_nxt[LO +: CHUNK] = add_sum;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q  <= 1'b0;
                s_q  <= '0;
                cy_q <= 1'b0;
            end else if (adv[k]) begin
                v_q <= v_in;
                if (v_in) begin
                    s_q  <= s_nxt;
                    cy_q <= add_co;
                end
            end
        end

        // Only the carry-row slices still to be added travel down the pipe.
        if (k < STAGES - 1) begin : g_hold
            logic [RW-CHUNK-1:0] c_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    c_q <= '0;
                end else if (adv[k] && v_in) begin
                    c_q <= c_in[RW-1:CHUNK];
                end
            end
        end

        assign v_vec[k] = v_q;
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign product   = g_stage[STAGES-1].s_q;
    assign cout      = g_stage[STAGES-1].cy_q;
endmodule
